// File: rtl/fxp_pkg.sv
// Shared fixed-point helpers and formats for the adaptive filter datapath.
`timescale 1ns/1ps
package fxp_pkg;

  typedef enum logic {RND_TRUNC = 1'b0, RND_HALF_UP = 1'b1} round_mode_e;

  localparam int ACC_WIDTH = 40;
  localparam int ACC_FRAC  = 30;

  // Filter accumulator format, Q9.30.
  typedef logic signed [ACC_WIDTH-1:0] acc_q9_30_t;

  function automatic longint fxp_max(input int width);
    return (longint'(1) <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic longint fxp_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/fxp_saturate.sv
// Combinational narrowing of a wide signed value to OUT_WIDTH bits, clamping or wrapping.
`timescale 1ns/1ps
module fxp_saturate
  import fxp_pkg::*;
#(
  parameter int IN_WIDTH  = 41,
  parameter int OUT_WIDTH = 16,
  parameter int SATURATE  = 1
) (
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        ovf
);

  localparam logic signed [OUT_WIDTH-1:0] MAX_V = OUT_WIDTH'(fxp_max(OUT_WIDTH));
  localparam logic signed [OUT_WIDTH-1:0] MIN_V = OUT_WIDTH'(fxp_min(OUT_WIDTH));

  // The value fits exactly when every bit from the output sign bit upward agrees.
  logic [IN_WIDTH-OUT_WIDTH:0] upper;
  assign upper = din[IN_WIDTH-1:OUT_WIDTH-1];
  assign ovf   = !((&upper) || !(|upper));

  always_comb begin
    dout = din[OUT_WIDTH-1:0];
    if (SATURATE != 0 && ovf) begin
      dout = din[IN_WIDTH-1] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/fxp_requantizer.sv
// Two-stage signed fixed-point narrowing converter: align/round, then saturate,
// with valid/ready handshakes on both sides and a sticky overflow counter.
`timescale 1ns/1ps
module fxp_requantizer
  import fxp_pkg::*;
#(
  parameter int DIN_WIDTH  = 40,
  parameter int DIN_FRAC   = 30,
  parameter int DOUT_WIDTH = 16,
  parameter int DOUT_FRAC  = 15,
  parameter int ROUND_MODE = 1,
  parameter int SATURATE   = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [DIN_WIDTH-1:0]  s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic signed [DOUT_WIDTH-1:0] m_data,
  output logic                         ovf_flag,
  output logic [CNT_WIDTH-1:0]         ovf_count,
  input  logic                         clr_ovf
);

  localparam int SH = DIN_FRAC - DOUT_FRAC;
  localparam int AW = (SH > 0) ? DIN_WIDTH + 1 : DIN_WIDTH + 1 - SH;

  if (DOUT_WIDTH > DIN_WIDTH + DOUT_FRAC - DIN_FRAC + 1) begin : g_width_check
    $error("fxp_requantizer: output wider than aligned input; use the widening converter");
  end

  logic signed [AW-1:0] aligned;
  logic signed [AW-1:0] a1;
  logic                 v1;
  logic                 load1;
  logic                 load2;
  logic signed [DOUT_WIDTH-1:0] sat_data;
  logic                 sat_ovf;
  logic                 ovf_event;

  if (SH > 0) begin : g_shift_right
    localparam logic signed [AW-1:0] HALF =
      (ROUND_MODE == int'(RND_HALF_UP)) ? (AW'(1) << (SH - 1)) : '0;
    logic signed [AW-1:0] ext;
    logic signed [AW-1:0] rnd;
    assign ext     = {s_data[DIN_WIDTH-1], s_data};
    assign rnd     = ext + HALF;
    assign aligned = rnd >>> SH;
  end else begin : g_shift_left
    assign aligned = {{(1 - SH){s_data[DIN_WIDTH-1]}}, s_data} <<< (-SH);
  end

  fxp_saturate #(
    .IN_WIDTH  (AW),
    .OUT_WIDTH (DOUT_WIDTH),
    .SATURATE  (SATURATE)
  ) u_sat (
    .din  (a1),
    .dout (sat_data),
    .ovf  (sat_ovf)
  );

  // s_ready looks through both stages combinationally so full-rate flow has no bubble.
  assign load2     = !m_valid || m_ready;
  assign load1     = !v1 || load2;
  assign s_ready   = load1;
  assign ovf_event = load2 && v1 && sat_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      a1      <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      if (load1) begin
        v1 <= s_valid;
        if (s_valid) a1 <= aligned;
      end
      if (load2) begin
        m_valid <= v1;
        if (v1) m_data <= sat_data;
      end
    end
  end

  // A clear coinciding with an overflow keeps that new event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_flag  <= 1'b0;
      ovf_count <= '0;
    end else if (clr_ovf) begin
      ovf_flag  <= ovf_event;
      ovf_count <= ovf_event ? CNT_WIDTH'(1) : '0;
    end else if (ovf_event) begin
      ovf_flag <= 1'b1;
      if (ovf_count != '1) ovf_count <= ovf_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fxp_requantizer.sv
// Scoreboard bench: default instance plus a truncate/wrap/2-bit-counter instance on shared stimulus.
`timescale 1ns/1ps
module tb_fxp_requantizer;

  localparam int DIN_W = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic [39:0] s_data;
  logic        m_ready;
  logic        clr_ovf;

  logic        s_ready_a, m_valid_a, ovf_flag_a;
  logic [15:0] m_data_a;
  logic [15:0] ovf_count_a;
  logic        s_ready_b, m_valid_b, ovf_flag_b;
  logic [15:0] m_data_b;
  logic [1:0]  ovf_count_b;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int stall_lo = 0;
  int stall_hi = 0;
  bit rand_ready = 1'b0;
  int stall_acc = 0;
  int n_out_a = 0;
  int exp_cnt_a = 0;
  int exp_cnt_b = 0;
  logic [15:0] q_a[$];
  logic [15:0] q_b[$];

  always #5 clk = ~clk;

  fxp_requantizer dut_a (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data),
    .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a),
    .ovf_flag(ovf_flag_a), .ovf_count(ovf_count_a), .clr_ovf(clr_ovf)
  );

  fxp_requantizer #(.ROUND_MODE(0), .SATURATE(0), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
    .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b),
    .ovf_flag(ovf_flag_b), .ovf_count(ovf_count_b), .clr_ovf(clr_ovf)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: Q9.30 -> Q0.15 via integer arithmetic on a 64-bit value.
  function automatic void model(input longint x, input bit rnd, input bit sat,
                                output logic [15:0] y, output bit ovf);
    longint v;
    v = x + (rnd ? 64'sd16384 : 64'sd0);
    v = v >>> 15;
    ovf = (v > 64'sd32767) || (v < -64'sd32768);
    if (sat && v > 64'sd32767)       y = 16'h7FFF;
    else if (sat && v < -64'sd32768) y = 16'h8000;
    else                             y = v[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
    else            m_ready = !(cycle >= stall_lo && cycle < stall_hi);
  endtask

  task automatic applyStimulus(input longint x);
    bit done;
    int waited;
    done = 1'b0;
    waited = 0;
    s_valid = 1'b1;
    s_data  = x[DIN_W-1:0];
    while (!done) begin
      @(negedge clk);
      done = s_ready_a;
      tick();
      waited++;
      if (!done && waited > 100) begin
        checks++;
        errors++;
        $display("[TB] FAIL acceptTimeout: got no s_ready, expected acceptance within 100 cycles");
        done = 1'b1;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || m_valid_a) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("[TB] FAIL drainTimeout: got %0d pending, expected 0", q_a.size());
    end
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_cntA"}, 32'(ovf_count_a), 32'(exp_cnt_a));
    checkOutput({tag, "_flagA"}, 32'(ovf_flag_a), 32'(exp_cnt_a != 0));
    checkOutput({tag, "_cntB"}, 32'(ovf_count_b), 32'(exp_cnt_b));
    checkOutput({tag, "_flagB"}, 32'(ovf_flag_b), 32'(exp_cnt_b != 0));
  endtask

  // Push expectations on acceptance, pop and compare on each output transfer.
  always @(negedge clk) begin
    logic [15:0] y;
    bit ovf;
    if (rst_n) begin
      if (s_valid && s_ready_a) begin
        model(longint'($signed(s_data)), 1'b1, 1'b1, y, ovf);
        q_a.push_back(y);
        if (ovf && exp_cnt_a < 65535) exp_cnt_a++;
      end
      if (s_valid && s_ready_b) begin
        model(longint'($signed(s_data)), 1'b0, 1'b0, y, ovf);
        q_b.push_back(y);
        if (ovf && exp_cnt_b < 3) exp_cnt_b++;
      end
      if (!m_ready && s_valid && s_ready_a) stall_acc++;
      if (m_valid_a && m_ready) begin
        n_out_a++;
        if (q_a.size() == 0) checkOutput("unexpectedA", 32'(m_data_a), 32'hDEAD_0000);
        else checkOutput("dataA", 32'(m_data_a), 32'(q_a.pop_front()));
      end
      if (m_valid_b && m_ready) begin
        if (q_b.size() == 0) checkOutput("unexpectedB", 32'(m_data_b), 32'hDEAD_0000);
        else checkOutput("dataB", 32'(m_data_b), 32'(q_b.pop_front()));
      end
      if (m_valid_a && !m_ready && q_a.size() != 0)
        checkOutput("holdA", 32'(m_data_a), 32'(q_a[0]));
    end
  end

  initial begin
    longint vec[6];
    int base;
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    m_ready = 1'b1;
    clr_ovf = 1'b0;
    #1;
    checkOutput("rst_mvalid", 32'(m_valid_a), 32'd0);
    checkOutput("rst_mdata", 32'(m_data_a), 32'd0);
    checkOutput("rst_flag", 32'(ovf_flag_a), 32'd0);
    checkOutput("rst_count", 32'(ovf_count_a), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checkOutput("rst_sready", 32'(s_ready_a), 32'd1);

    $display("[TB] basic latency");
    applyStimulus(64'sd1 <<< 29);
    checkOutput("lat_cycle1", 32'(m_valid_a), 32'd0);
    tick();
    checkOutput("lat_cycle2", 32'(m_valid_a), 32'd1);
    checkOutput("lat_data", 32'(m_data_a), 32'h4000);
    drain();
    checkOutput("basic_flag", 32'(ovf_flag_a), 32'd0);

    $display("[TB] rounding");
    vec[0] = 64'sd16384;
    vec[1] = 64'sd16383;
    vec[2] = -64'sd16384;
    vec[3] = -64'sd16385;
    vec[4] = -64'sd1;
    vec[5] = 64'sd98304;
    foreach (vec[i]) applyStimulus(vec[i]);
    drain();
    checkCounters("round");

    $display("[TB] saturation");
    applyStimulus(64'sd1 <<< 31);
    applyStimulus(-64'sd3 <<< 30);
    drain();
    checkCounters("sat");
    for (int i = 0; i < 3; i++) applyStimulus(64'sd5 <<< 31);
    drain();
    checkCounters("cntstick");

    $display("[TB] clear coincident with overflow");
    applyStimulus(64'sd1 <<< 32);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    exp_cnt_a = 1;
    exp_cnt_b = 1;
    checkCounters("clrovf");
    drain();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    exp_cnt_a = 0;
    exp_cnt_b = 0;
    checkCounters("clr");

    $display("[TB] backpressure ramp");
    base = n_out_a;
    for (int i = 0; i < 4; i++) applyStimulus((longint'(i * 3000 - 9000) <<< 15) + 64'sd12345);
    repeat (3) tick();
    stall_acc = 0;
    stall_lo = cycle;
    stall_hi = cycle + 5;
    m_ready = 1'b0;
    for (int i = 4; i < 8; i++) applyStimulus((longint'(i * 3000 - 9000) <<< 15) + 64'sd12345);
    drain();
    checkOutput("stall_accepts", 32'(stall_acc), 32'd2);
    checkOutput("ramp_count", 32'(n_out_a - base), 32'd8);
    checkCounters("ramp");

    $display("[TB] random data with random m_ready");
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++)
      applyStimulus((longint'($signed($urandom)) <<< 2) + longint'($urandom_range(0, 3)));
    rand_ready = 1'b0;
    drain();
    checkCounters("rand");

    $display("[TB] reset mid-stream");
    applyStimulus(64'sd7 <<< 26);
    applyStimulus(64'sd9 <<< 26);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_mvalid", 32'(m_valid_a), 32'd0);
    checkOutput("midrst_mdata", 32'(m_data_a), 32'd0);
    q_a.delete();
    q_b.delete();
    exp_cnt_a = 0;
    exp_cnt_b = 0;
    tick();
    rst_n = 1'b1;
    base = n_out_a;
    applyStimulus(-64'sd5 <<< 27);
    drain();
    checkOutput("postrst_count", 32'(n_out_a - base), 32'd1);
    checkCounters("postrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL globalTimeout: got no finish, expected finish before 2 ms");
    $fatal(1, "[TB] timeout");
  end

endmodule
